// File: rtl/bullet_engine.sv
// Bullet engine: spawns, moves and retires one bullet at a time per wave,
// detects heart collisions and emits one-clock damage/heal pulses.
module bullet_engine #(
    parameter int          NUM_BULLETS = 8,
    parameter int          SPEED       = 2,
    parameter int          GAP_FRAMES  = 30,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          AREA_MAX    = 200,
    parameter int          HIT_R       = 16,
    parameter int          BLUE_R      = 58
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic [15:0] playerPos,
    output logic [15:0] bulletPos,
    output logic [1:0]  bulletColor,
    output logic        isRender,
    output logic        hit_damage,
    output logic        hit_heal,
    output logic        busy,
    output logic        wave_done
);

    localparam logic [7:0] AMAX     = 8'(AREA_MAX);
    localparam logic [7:0] SPD      = 8'(SPEED);
    localparam logic [8:0] R_HIT    = 9'(HIT_R);
    localparam logic [8:0] R_BLUE   = 9'(BLUE_R);
    localparam logic [7:0] NB       = 8'(NUM_BULLETS);
    localparam int         GW       = $clog2(GAP_FRAMES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_FRAMES - 1);

    typedef enum logic [2:0] {IDLE, SPAWN, MOVE, GAP, DONE} state_t;

    state_t         state;
    logic [15:0]    lfsr;
    logic [7:0]     bullet_cnt;
    logic [GW-1:0]  gap_cnt;
    logic [15:0]    player_prev;
    logic [1:0]     dir;

    logic [7:0]        offset;
    logic [15:0]       lfsr_next;
    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic [8:0]        adx;
    logic [8:0]        ady;
    logic [8:0]        radius;
    logic              collide;
    logic              moved;
    logic [7:0]        axis_pos;
    logic [7:0]        stepped;
    logic              exit_area;
    logic              ev_damage;
    logic              ev_heal;

    always_comb begin
        offset    = (lfsr[7:0] > AMAX) ? lfsr[7:0] - 8'd56 : lfsr[7:0];
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        dx        = $signed({1'b0, bulletPos[15:8]}) - $signed({1'b0, playerPos[15:8]});
        dy        = $signed({1'b0, bulletPos[7:0]}) - $signed({1'b0, playerPos[7:0]});
        adx       = dx[8] ? $unsigned(-dx) : $unsigned(dx);
        ady       = dy[8] ? $unsigned(-dy) : $unsigned(dy);
        radius    = (bulletColor == 2'd2) ? R_BLUE : R_HIT;
        collide   = (adx <= radius) && (ady <= radius);
        moved     = (playerPos != player_prev);
        // dir[1] selects the y axis, dir[0] selects the negative direction
        axis_pos  = dir[1] ? bulletPos[7:0] : bulletPos[15:8];
        stepped   = dir[0] ? axis_pos - SPD : axis_pos + SPD;
        exit_area = dir[0] ? (axis_pos < SPD)
                           : (({1'b0, axis_pos} + {1'b0, SPD}) > {1'b0, AMAX});
        ev_damage = collide && ((bulletColor == 2'd0) || ((bulletColor == 2'd2) && moved));
        ev_heal   = collide && (bulletColor == 2'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lfsr        <= SEED;
            bullet_cnt  <= 8'd0;
            gap_cnt     <= '0;
            player_prev <= 16'd0;
            dir         <= 2'd0;
            bulletPos   <= 16'd0;
            bulletColor <= 2'd0;
            isRender    <= 1'b0;
            hit_damage  <= 1'b0;
            hit_heal    <= 1'b0;
            busy        <= 1'b0;
            wave_done   <= 1'b0;
        end else begin
            hit_damage <= 1'b0;
            hit_heal   <= 1'b0;
            if (frame_tick) begin
                player_prev <= playerPos;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= SPAWN;
                        wave_done  <= 1'b0;
                        bullet_cnt <= 8'd0;
                        busy       <= 1'b1;
                    end
                end
                SPAWN: begin
                    dir <= lfsr[11:10];
                    case (lfsr[11:10])
                        2'b00:   bulletPos <= {8'd0, offset};
                        2'b01:   bulletPos <= {AMAX, offset};
                        2'b10:   bulletPos <= {offset, 8'd0};
                        default: bulletPos <= {offset, AMAX};
                    endcase
                    bulletColor <= (lfsr[9:8] == 2'd3) ? 2'd0 : lfsr[9:8];
                    isRender    <= 1'b1;
                    bullet_cnt  <= bullet_cnt + 8'd1;
                    lfsr        <= lfsr_next;
                    state       <= MOVE;
                end
                MOVE: begin
                    if (frame_tick) begin
                        if (ev_damage || ev_heal) begin
                            hit_damage <= ev_damage;
                            hit_heal   <= ev_heal;
                            isRender   <= 1'b0;
                            state      <= GAP;
                        end else if (exit_area) begin
                            isRender <= 1'b0;
                            state    <= GAP;
                        end else if (dir[1]) begin
                            bulletPos[7:0] <= stepped;
                        end else begin
                            bulletPos[15:8] <= stepped;
                        end
                    end
                end
                GAP: begin
                    if (frame_tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt <= '0;
                            if (bullet_cnt < NB) begin
                                state <= SPAWN;
                            end else begin
                                state     <= DONE;
                                busy      <= 1'b0;
                                wave_done <= 1'b1;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine: default instance for spawn/move/hit/heal/reset,
// a short-wave instance (2 bullets, 3-frame gap) for wave completion.
module tb_bullet_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] playerPos = 16'd0;

    logic [15:0] bulletPos;
    logic [1:0]  bulletColor;
    logic        isRender, hit_damage, hit_heal, busy, wave_done;

    logic [15:0] b_bulletPos;
    logic [1:0]  b_bulletColor;
    logic        b_isRender, b_hit_damage, b_hit_heal, b_busy, b_wave_done;

    int checks = 0;
    int failures = 0;
    int dmg_cnt = 0;
    int heal_cnt = 0;
    int both_cnt = 0;
    int b_pulse_cnt = 0;

    bullet_engine dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .playerPos(playerPos), .bulletPos(bulletPos), .bulletColor(bulletColor),
        .isRender(isRender), .hit_damage(hit_damage), .hit_heal(hit_heal),
        .busy(busy), .wave_done(wave_done)
    );

    bullet_engine #(.NUM_BULLETS(2), .GAP_FRAMES(3)) dut_b (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start_b),
        .playerPos(playerPos), .bulletPos(b_bulletPos), .bulletColor(b_bulletColor),
        .isRender(b_isRender), .hit_damage(b_hit_damage), .hit_heal(b_hit_heal),
        .busy(b_busy), .wave_done(b_wave_done)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (hit_damage) dmg_cnt++;
        if (hit_heal) heal_cnt++;
        if (hit_damage && hit_heal) both_cnt++;
        if (b_hit_damage || b_hit_heal) b_pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_edge();
        frame_tick = 1'b1;
        clk1();
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_edge();
            clk1();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk1();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        clk1();
        start = 1'b0;
    endtask

    task automatic pulse_start_b();
        start_b = 1'b1;
        clk1();
        start_b = 1'b0;
    endtask

    initial begin
        #2;
        // reset state and first spawn
        do_reset();
        check("rst_pos", bulletPos, 32'h0);
        check("rst_outs", {bulletColor, isRender, hit_damage, hit_heal, busy, wave_done}, 32'h0);
        pulse_start();
        check("start_busy", busy, 32'h1);
        check("start_render", isRender, 32'h0);
        clk1();
        check("spawn1_pos", bulletPos, 32'hA9C8);
        check("spawn1_color", bulletColor, 32'h0);
        check("spawn1_flags", {isRender, busy, wave_done}, 32'b110);

        // white bullet moving up into a heart at (169,100)
        playerPos = {8'd169, 8'd100};
        ticks(42);
        check("s2_pos42", bulletPos, 32'hA974);
        check("s2_dmg_before", dmg_cnt, 32'd0);
        tick_edge();
        check("s2_hit", {hit_damage, hit_heal, isRender}, 32'b100);
        clk1();
        check("s2_hit_len", hit_damage, 32'h0);
        check("s2_dmg_cnt", dmg_cnt, 32'd1);

        // blue bullet, stationary player at (40,112): passes through
        playerPos = {8'd40, 8'd112};
        ticks(30);
        check("s4_spawn_pos", bulletPos, 32'h0070);
        check("s4_spawn_color", bulletColor, 32'h2);
        check("s4_spawn_render", isRender, 32'h1);
        ticks(100);
        check("s4_pos100", bulletPos, 32'hC870);
        check("s4_no_dmg", dmg_cnt, 32'd1);
        tick_edge();
        check("s4_exit_render", isRender, 32'h0);
        clk1();
        check("s4_exit_no_pulse", dmg_cnt + heal_cnt, 32'd1);

        // green bullet from (0,56), heart at (20,56): heal at distance exactly 16
        playerPos = {8'd20, 8'd56};
        ticks(30);
        check("g_spawn_pos", bulletPos, 32'h0038);
        check("g_spawn_color", bulletColor, 32'h1);
        ticks(2);
        check("g_pos2", bulletPos, 32'h0438);
        check("g_no_heal_yet", heal_cnt, 32'd0);
        tick_edge();
        check("g_heal", {hit_heal, hit_damage, isRender}, 32'b100);
        clk1();
        check("g_heal_cnt", heal_cnt, 32'd1);

        // reset during MOVE, then the wave restarts from the seed
        playerPos = 16'h0000;
        do_reset();
        pulse_start();
        clk1();
        ticks(5);
        check("r_pos_moving", bulletPos, 32'hA9BE);
        do_reset();
        check("r_mid_pos", bulletPos, 32'h0);
        check("r_mid_outs", {bulletColor, isRender, hit_damage, hit_heal, busy, wave_done}, 32'h0);
        pulse_start();
        clk1();
        check("r_respawn_pos", bulletPos, 32'hA9C8);
        check("r_respawn_flags", {bulletColor, isRender, busy}, 32'b0011);

        // white bullet sweeping to y=0 and leaving with no pulse
        ticks(1);
        check("s3_pos1", bulletPos, 32'hA9C6);
        ticks(99);
        check("s3_pos100", bulletPos, 32'hA900);
        check("s3_render100", isRender, 32'h1);
        tick_edge();
        check("s3_exit", {isRender, hit_damage, hit_heal}, 32'b000);
        clk1();
        check("s3_pulses", dmg_cnt + heal_cnt, 32'd2);

        // blue bullet with a moving player: damage on the first frame in range
        for (int i = 0; i < 30; i++) begin
            playerPos = {((i % 2) != 0) ? 8'd41 : 8'd40, 8'd112};
            ticks(1);
        end
        check("s4b_spawn_pos", bulletPos, 32'h0070);
        check("s4b_spawn_color", bulletColor, 32'h2);
        playerPos = {8'd40, 8'd112};
        tick_edge();
        check("s4b_hit", {hit_damage, hit_heal, isRender}, 32'b100);
        clk1();
        check("s4b_dmg_cnt", dmg_cnt, 32'd2);
        check("no_overlap", both_cnt, 32'd0);

        // short wave: 2 bullets, 3-frame gap, all exiting
        playerPos = 16'h0000;
        do_reset();
        check("b_rst", {b_busy, b_wave_done, b_isRender}, 32'b000);
        pulse_start_b();
        check("b_busy", b_busy, 32'h1);
        clk1();
        check("b_spawn1", b_bulletPos, 32'hA9C8);
        ticks(50);
        pulse_start_b();
        clk1();
        check("b_start_ignored_pos", b_bulletPos, 32'hA964);
        check("b_start_ignored_render", b_isRender, 32'h1);
        ticks(50);
        check("b_pos100", b_bulletPos, 32'hA900);
        ticks(1);
        check("b_exit1", b_isRender, 32'h0);
        ticks(3);
        check("b_spawn2_pos", b_bulletPos, 32'h0070);
        check("b_spawn2_flags", {b_bulletColor, b_isRender}, 32'b101);
        ticks(101);
        check("b_exit2", b_isRender, 32'h0);
        ticks(2);
        check("b_gap_busy", {b_busy, b_wave_done}, 32'b10);
        ticks(1);
        check("b_done", {b_busy, b_wave_done}, 32'b01);
        clk1();
        check("b_done_hold", {b_busy, b_wave_done}, 32'b01);
        pulse_start_b();
        check("b_restart", {b_busy, b_wave_done}, 32'b10);
        check("b_no_pulses", b_pulse_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
